key_entry: RTL and testbench
============================

# key_entry

Single-button digit entry block: the consumer end of a raw push-button line. It synchronizes and debounces an active-low key, classifies each press as short or long, and builds a decimal digit. Short presses step the digit; a long press commits it. It sits between the board KEY pin and the number-processing logic, such as the factorization core and the seg7 display path. DIGIT feeds the live display; VALUE/COMMIT feed downstream.

## Interface
- DEB_CYC, 500000 — consecutive stable cycles required to accept a new key level (10 ms @ 50 MHz); must be ≥ 2.
- LONG_CYC, 50000000 — press duration in debounced-pressed cycles that makes a press long (1 s @ 50 MHz); must be > 1.
- MAXV, 9 — largest digit value; DIGIT wraps MAXV→0; range 1..15.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- nKEY  in  1  raw push-button, active-low, asynchronous, bouncing.
- DIGIT  out  4  digit under edit.
- VALUE  out  4  last committed digit.
- COMMIT  out  1  one-cycle pulse when VALUE is loaded.
- HOLD  out  1  high from commit until key release.

## Operation
- Sync: nKEY inverted and passed through 2 flip-flops (reset value 0 = released) → key_s.
- Debounce: counter cnt_db.
  - When key_s ≠ deb (debounced level), cnt_db increments; otherwise it clears.
  - When cnt_db reaches DEB_CYC−1 and key_s still differs, deb toggles and cnt_db clears.
  - Any mismatch gap (key_s == deb) restarts the count.
- FSM states: IDLE, PRESS, LONG.
  - IDLE: deb rising → PRESS, cnt_dur ← 0.
  - PRESS: cnt_dur increments each cycle while deb = 1.
    - deb falls before cnt_dur reaches LONG_CYC−1: short press. DIGIT ← (DIGIT == MAXV) ? 0 : DIGIT+1; → IDLE.
    - cnt_dur reaches LONG_CYC−1 with deb = 1: long press. VALUE ← DIGIT, COMMIT = 1 for that cycle, DIGIT ← 0, HOLD ← 1; → LONG.
  - LONG: ignores duration. deb falls → HOLD ← 0; → IDLE; DIGIT not stepped.
- Exactly one action per press: a step, or a commit.
- Counters saturate: cnt_dur holds at LONG_CYC−1; cnt_db never exceeds DEB_CYC−1.
- Counter widths are $clog2 of their limit. VALUE/DIGIT are 4-bit unsigned.
- DIGIT > MAXV cannot occur.

## Timing
- Reset values: DIGIT = 0, VALUE = 0, COMMIT = 0, HOLD = 0, deb = 0, FSM = IDLE, all counters 0.
- Reset is effective immediately and asynchronously, including mid-press. After reset release, a key already held is debounced as a new press: deb rises DEB_CYC cycles after the sync pipeline shows 1.
- Press latency: raw stable low at edge t → key_s = 1 at t+2 → deb = 1 at t+2+DEB_CYC.
- Release latency: same, 2+DEB_CYC cycles.
- Short-press step:
  - DIGIT updates on the cycle after deb falls (registered).
  - Press length counts from the deb rise cycle through the last cycle of deb = 1.
- Long commit:
  - COMMIT, the VALUE load, the DIGIT clear, and HOLD rise all occur on the same edge.
  - That edge is LONG_CYC cycles after the cycle where the FSM entered PRESS.
- Simultaneous deb fall and cnt_dur == LONG_CYC−1: fall wins, and the press is treated as short.
- Glitches shorter than DEB_CYC cycles never change deb or any output.

## Test plan
Bench parameters: DEB_CYC=4, LONG_CYC=20, MAXV=9.

- Reset, nKEY=1 idle 100 cycles → DIGIT=0, VALUE=0, COMMIT never 1, HOLD=0.
- Three clean presses, each held 10 cycles debounced, spaced 20 cycles → DIGIT steps 1,2,3; COMMIT stays 0.
- Ten presses from DIGIT=0 → DIGIT reaches 9, then wraps to 0 on the 10th press.
- DIGIT=3, then hold the key 40 cycles:
  - exactly one COMMIT pulse, 20 cycles after the PRESS entry;
  - VALUE=3, DIGIT=0;
  - HOLD high until 2+4 cycles after the raw release, then low;
  - DIGIT stays 0 on release.
- Bounce: raw toggles with pulses of 1–3 cycles for 30 cycles, then settles low for 30 cycles → exactly one debounced press; DIGIT increments once on release.
- Reset asserted mid-long-press (cnt_dur=10, DIGIT=5) → all outputs 0 at once. Key still held after release → after 2+4 cycles a new PRESS begins; commit at +20 with VALUE=0.

Source files
------------

// File: rtl/key_entry_if.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_if
// Brief    : Key pin in, digit/value/commit/hold out for the key entry block.
// Revision : 1.0
// ============================================================================
interface key_entry_if;
   logic       n_key;
   logic [3:0] digit;
   logic [3:0] value;
   logic       commit;
   logic       hold;

   modport master (output n_key, input digit, value, commit, hold);
   modport slave  (input n_key, output digit, value, commit, hold);
endinterface
`default_nettype wire

// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
// Module   : key_entry
// Brief    : Debounced single-button digit entry; short press steps, long commits.
// Revision : 1.0
// ============================================================================
module key_entry #(
   parameter int DEB_CYC  = 500000,
   parameter int LONG_CYC = 50000000,
   parameter int MAXV     = 9
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   key_entry_if.slave key_if
);
   localparam int DB_W  = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
   localparam int DUR_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
   localparam logic [DB_W-1:0]  C_DB_MAX  = DB_W'(DEB_CYC - 1);
   localparam logic [DUR_W-1:0] C_DUR_MAX = DUR_W'(LONG_CYC - 1);
   localparam logic [3:0]       C_MAXV    = 4'(MAXV);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRESS = 2'd1,
      S_LONG  = 2'd2
   } state_t;

   logic [1:0]       sync_q,    sync_d;
   logic             deb_q,     deb_d;
   logic [DB_W-1:0]  cnt_db_q,  cnt_db_d;
   state_t           state_q,   state_d;
   logic [DUR_W-1:0] cnt_dur_q, cnt_dur_d;
   logic [3:0]       digit_q,   digit_d;
   logic [3:0]       value_q,   value_d;
   logic             commit_q,  commit_d;
   logic             hold_q,    hold_d;
   logic             key_s;

   assign key_s = sync_q[1];

   // Key is inverted on entry so that 1 means pressed throughout.
   always_comb begin
      sync_d   = {sync_q[0], ~key_if.n_key};
      deb_d    = deb_q;
      cnt_db_d = '0;
      if (key_s != deb_q) begin
         if (cnt_db_q == C_DB_MAX) begin
            deb_d = ~deb_q;
         end else begin
            cnt_db_d = cnt_db_q + 1'b1;
         end
      end
   end

   // A falling deb is checked before the duration limit so a tie is a short press.
   always_comb begin
      state_d   = state_q;
      cnt_dur_d = cnt_dur_q;
      digit_d   = digit_q;
      value_d   = value_q;
      commit_d  = 1'b0;
      hold_d    = hold_q;
      case (state_q)
         S_IDLE: begin
            if (deb_q) begin
               state_d   = S_PRESS;
               cnt_dur_d = '0;
            end
         end
         S_PRESS: begin
            if (!deb_q) begin
               digit_d = (digit_q == C_MAXV) ? 4'd0 : digit_q + 4'd1;
               state_d = S_IDLE;
            end else if (cnt_dur_q == C_DUR_MAX) begin
               value_d  = digit_q;
               commit_d = 1'b1;
               digit_d  = 4'd0;
               hold_d   = 1'b1;
               state_d  = S_LONG;
            end else begin
               cnt_dur_d = cnt_dur_q + 1'b1;
            end
         end
         S_LONG: begin
            if (!deb_q) begin
               hold_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         deb_q     <= 1'b0;
         cnt_db_q  <= '0;
         state_q   <= S_IDLE;
         cnt_dur_q <= '0;
         digit_q   <= 4'd0;
         value_q   <= 4'd0;
         commit_q  <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         deb_q     <= deb_d;
         cnt_db_q  <= cnt_db_d;
         state_q   <= state_d;
         cnt_dur_q <= cnt_dur_d;
         digit_q   <= digit_d;
         value_q   <= value_d;
         commit_q  <= commit_d;
         hold_q    <= hold_d;
      end
   end

   assign key_if.digit  = digit_q;
   assign key_if.value  = value_q;
   assign key_if.commit = commit_q;
   assign key_if.hold   = hold_q;
endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_entry
// Brief    : Directed vector bench for key_entry (DEB_CYC=4, LONG_CYC=20, MAXV=9).
// Revision : 1.0
// ============================================================================
module tb_key_entry;
   localparam int DEB  = 4;
   localparam int LNG  = 20;
   localparam int MAXV = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   key_entry_if kif();

   key_entry #(.DEB_CYC(DEB), .LONG_CYC(LNG), .MAXV(MAXV)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_if (kif)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int n_commits = 0;
   int last_commit_cyc = -1;

   always @(negedge clk) begin
      if (kif.commit === 1'b1) begin
         n_commits++;
         last_commit_cyc = cyc;
      end
   end

   typedef struct {
      int hold_c;
      int gap_c;
      int exp_digit;
      int exp_value;
      int exp_hold;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic press(input int hold_c, input int gap_c);
      kif.n_key = 1'b0;
      idle(hold_c);
      kif.n_key = 1'b1;
      idle(gap_c);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c0;
      int c1;
      int r;
      int base;
      int blen[14];

      // Ten steps wrapping 9 -> 0, then three more to reach 3.
      vecs[0]  = '{10, 20, 1, 0, 0};
      vecs[1]  = '{10, 20, 2, 0, 0};
      vecs[2]  = '{10, 20, 3, 0, 0};
      vecs[3]  = '{10, 20, 4, 0, 0};
      vecs[4]  = '{10, 20, 5, 0, 0};
      vecs[5]  = '{10, 20, 6, 0, 0};
      vecs[6]  = '{10, 20, 7, 0, 0};
      vecs[7]  = '{10, 20, 8, 0, 0};
      vecs[8]  = '{10, 20, 9, 0, 0};
      vecs[9]  = '{10, 20, 0, 0, 0};
      vecs[10] = '{10, 20, 1, 0, 0};
      vecs[11] = '{10, 20, 2, 0, 0};
      vecs[12] = '{10, 20, 3, 0, 0};

      kif.n_key = 1'b1;
      rst_n     = 1'b0;
      idle(3);
      check("reset_digit",  int'(kif.digit),  0);
      check("reset_value",  int'(kif.value),  0);
      check("reset_hold",   int'(kif.hold),   0);
      check("reset_commit", int'(kif.commit), 0);
      rst_n = 1'b1;

      idle(100);
      check("idle_digit",   int'(kif.digit), 0);
      check("idle_value",   int'(kif.value), 0);
      check("idle_hold",    int'(kif.hold),  0);
      check("idle_commits", n_commits,       0);

      for (int i = 0; i < 13; i++) begin
         press(vecs[i].hold_c, vecs[i].gap_c);
         check($sformatf("vec%0d_digit", i), int'(kif.digit), vecs[i].exp_digit);
         check($sformatf("vec%0d_value", i), int'(kif.value), vecs[i].exp_value);
         check($sformatf("vec%0d_hold", i),  int'(kif.hold),  vecs[i].exp_hold);
      end
      check("short_no_commit", n_commits, 0);

      // Long press at DIGIT=3: key low after cyc c0 -> deb up at c0+6, PRESS at c0+7, commit at c0+27.
      base = n_commits;
      c0 = cyc;
      kif.n_key = 1'b0;
      wait_cyc(c0 + 3 + DEB + LNG - 1);
      check("long_pre_commits", n_commits - base, 0);
      check("long_pre_hold",    int'(kif.hold),   0);
      check("long_pre_digit",   int'(kif.digit),  3);
      wait_cyc(c0 + 3 + DEB + LNG);
      check("long_commit", int'(kif.commit), 1);
      check("long_value",  int'(kif.value),  3);
      check("long_digit",  int'(kif.digit),  0);
      check("long_hold",   int'(kif.hold),   1);
      wait_cyc(c0 + 40);
      check("long_one_commit",  n_commits - base, 1);
      check("long_commit_time", last_commit_cyc,  c0 + 3 + DEB + LNG);
      c1 = cyc;
      kif.n_key = 1'b1;
      wait_cyc(c1 + 2 + DEB);
      check("hold_before_drop", int'(kif.hold), 1);
      wait_cyc(c1 + 3 + DEB);
      check("hold_dropped", int'(kif.hold), 0);
      idle(10);
      check("long_rel_digit",   int'(kif.digit),  0);
      check("long_rel_value",   int'(kif.value),  3);
      check("long_rel_commits", n_commits - base, 1);

      // Bounce with runs of 1..3 cycles, then a clean short press.
      blen = '{1, 2, 3, 1, 2, 3, 3, 2, 1, 3, 2, 1, 3, 3};
      base = n_commits;
      for (int i = 0; i < 14; i++) begin
         kif.n_key = (i % 2 == 0) ? 1'b0 : 1'b1;
         idle(blen[i]);
      end
      idle(8);
      check("bounce_digit",   int'(kif.digit),  0);
      check("bounce_commits", n_commits - base, 0);
      press(12, 20);
      check("bounce_press_digit",   int'(kif.digit),  1);
      check("bounce_press_commits", n_commits - base, 0);
      check("bounce_press_hold",    int'(kif.hold),   0);

      // Reach DIGIT=5, then reset while cnt_dur=10.
      for (int i = 0; i < 4; i++) press(10, 20);
      check("pre_reset_digit", int'(kif.digit), 5);
      c0 = cyc;
      kif.n_key = 1'b0;
      wait_cyc(c0 + 3 + DEB + 10);
      check("pre_reset_hold", int'(kif.hold), 0);
      rst_n = 1'b0;
      #1;
      check("async_rst_digit",  int'(kif.digit),  0);
      check("async_rst_value",  int'(kif.value),  0);
      check("async_rst_hold",   int'(kif.hold),   0);
      check("async_rst_commit", int'(kif.commit), 0);
      idle(2);
      rst_n = 1'b1;
      r = cyc;
      base = n_commits;
      wait_cyc(r + 2 + DEB + LNG);
      check("rst_pre_commits", n_commits - base, 0);
      wait_cyc(r + 3 + DEB + LNG);
      check("rst_commit",       int'(kif.commit), 1);
      check("rst_commit_value", int'(kif.value),  0);
      check("rst_commit_hold",  int'(kif.hold),   1);
      idle(1);
      check("rst_commit_time", last_commit_cyc, r + 3 + DEB + LNG);
      kif.n_key = 1'b1;
      idle(20);
      check("rst_final_hold",    int'(kif.hold),   0);
      check("rst_final_digit",   int'(kif.digit),  0);
      check("rst_final_commits", n_commits - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
